// File: rtl/step_clock_ctrl.sv
// Step clock controller: debounces the step pushbutton into single-cycle step
// pulses, adds a prescaled auto-run mode, and counts issued steps.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   IDLE     | manual mode, waiting for a debounced press or run request
//   WAIT_REL | manual step issued, waiting for the button to be released
//   RUN      | auto-run, prescaler issues a step every RUN_DIV cycles
module step_clock_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned RUN_DIV         = 25000000,
  parameter int unsigned CNT_W           = 25
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_n,
  input  logic       run_sel,
  output logic       step,
  output logic       key_level,
  output logic       run_active,
  output logic [7:0] step_count
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_REL = 2'd1,
    RUN      = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] DEB_TC = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RUN_TC = CNT_W'(RUN_DIV - 1);

  logic [1:0]       key_sync;
  logic [1:0]       run_sync;
  logic             key_s;
  logic             run_s;
  logic [CNT_W-1:0] deb_cnt;
  logic [CNT_W-1:0] pre_cnt;
  logic [CNT_W-1:0] pre_cnt_nxt;
  logic             press_ev;
  logic             step_nxt;
  state_t           state;
  state_t           state_nxt;

  // Synchronisers start at "released" / manual so reset never looks like a press
  always_ff @(posedge clk) begin
    if (reset) begin
      key_sync <= 2'b11;
      run_sync <= 2'b00;
    end else begin
      key_sync <= {key_sync[0], key_n};
      run_sync <= {run_sync[0], run_sel};
    end
  end

  assign key_s = ~key_sync[1];
  assign run_s = run_sync[1];

  always_ff @(posedge clk) begin
    if (reset) begin
      deb_cnt   <= '0;
      key_level <= 1'b0;
      press_ev  <= 1'b0;
    end else begin
      press_ev <= 1'b0;
      if (key_s == key_level) begin
        deb_cnt <= '0;
      end else if (deb_cnt == DEB_TC) begin
        key_level <= key_s;
        deb_cnt   <= '0;
        press_ev  <= key_s;
      end else begin
        deb_cnt <= deb_cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      step    <= 1'b0;
      pre_cnt <= '0;
    end else begin
      state   <= state_nxt;
      step    <= step_nxt;
      pre_cnt <= pre_cnt_nxt;
    end
  end

  // A press that lands while in RUN is dropped, so a held button never steps on exit
  always_comb begin
    state_nxt   = state;
    step_nxt    = 1'b0;
    pre_cnt_nxt = pre_cnt;
    case (state)
      IDLE: begin
        if (run_s) begin
          state_nxt   = RUN;
          pre_cnt_nxt = '0;
        end else if (press_ev) begin
          state_nxt = WAIT_REL;
          step_nxt  = 1'b1;
        end
      end
      WAIT_REL: begin
        if (!key_level) state_nxt = IDLE;
      end
      RUN: begin
        if (!run_s) begin
          state_nxt   = IDLE;
          pre_cnt_nxt = '0;
        end else if (pre_cnt == RUN_TC) begin
          step_nxt    = 1'b1;
          pre_cnt_nxt = '0;
        end else begin
          pre_cnt_nxt = pre_cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nxt   = IDLE;
        pre_cnt_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      step_count <= 8'd0;
    end else if (step) begin
      step_count <= step_count + 8'd1;
    end
  end

  assign run_active = (state == RUN);

endmodule

// File: tb/tb_step_clock_ctrl.sv
// Directed bench for step_clock_ctrl with DEBOUNCE_CYCLES=4, RUN_DIV=5;
// expected step positions are hand-derived from sync + debounce + FSM latency.
module tb_step_clock_ctrl;

  logic       clk;
  logic       reset;
  logic       key_n;
  logic       run_sel;
  logic       step;
  logic       key_level;
  logic       run_active;
  logic [7:0] step_count;

  int tests_run;
  int tests_failed;
  int cyc;
  int steps;
  int dbl;
  int cyc0;
  int guard;
  int step_cycles[$];
  logic prev_step;
  logic kl_seen;

  step_clock_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .RUN_DIV        (5),
    .CNT_W          (8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .key_n     (key_n),
    .run_sel   (run_sel),
    .step      (step),
    .key_level (key_level),
    .run_active(run_active),
    .step_count(step_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Advance one clock and sample 1 ns after the edge
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (step === 1'b1) begin
      steps++;
      step_cycles.push_back(cyc - cyc0);
      if (prev_step === 1'b1) dbl++;
    end
    prev_step = step;
    if (key_level === 1'b1) kl_seen = 1'b1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_step(input string tag);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (step !== 1'b1 && n < 50);
    check(tag, int'(step), 1);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    cyc          = 0;
    cyc0         = 0;
    steps        = 0;
    dbl          = 0;
    prev_step    = 1'b0;
    kl_seen      = 1'b0;
    reset        = 1'b1;
    key_n        = 1'b1;
    run_sel      = 1'b0;

    // 1. reset state
    ticks(3);
    check("rst_step", int'(step), 0);
    check("rst_key_level", int'(key_level), 0);
    check("rst_run_active", int'(run_active), 0);
    check("rst_step_count", int'(step_count), 0);
    reset = 1'b0;
    steps = 0;
    ticks(20);
    check("idle_no_step", steps, 0);

    // 2. clean press: key_level at +6, step at +7
    steps = 0;
    step_cycles.delete();
    cyc0  = cyc;
    key_n = 1'b0;
    ticks(20);
    check("press_key_level", int'(key_level), 1);
    key_n = 1'b1;
    ticks(20);
    check("press_steps", steps, 1);
    check("press_step_pos", (step_cycles.size() > 0) ? step_cycles[0] : -1, 7);
    check("press_count", int'(step_count), 1);
    check("release_key_level", int'(key_level), 0);

    // 3. bounce shorter than debounce window
    steps   = 0;
    kl_seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      key_n = 1'b0;
      ticks(2);
      key_n = 1'b1;
      ticks(2);
    end
    ticks(10);
    check("bounce_key_level", int'(kl_seen), 0);
    check("bounce_steps", steps, 0);
    check("bounce_count", int'(step_count), 1);

    // 4. auto-run: RUN at +3, steps at +8,+13,+18,+23,+28
    steps = 0;
    step_cycles.delete();
    cyc0    = cyc;
    run_sel = 1'b1;
    ticks(3);
    check("run_active_on", int'(run_active), 1);
    ticks(23);
    run_sel = 1'b0;
    ticks(20);
    check("run_steps", steps, 5);
    for (int i = 0; i < 5; i++)
      check($sformatf("run_step_pos%0d", i),
            (step_cycles.size() > i) ? step_cycles[i] : -1, 8 + 5 * i);
    check("run_active_off", int'(run_active), 0);
    check("run_count", int'(step_count), 6);

    // 5. press held across run on/off: only the 2 auto steps, none at exit
    steps = 0;
    step_cycles.delete();
    cyc0    = cyc;
    run_sel = 1'b1;
    ticks(3);
    key_n = 1'b0;
    ticks(9);
    run_sel = 1'b0;
    ticks(20);
    check("held_steps", steps, 2);
    check("held_key_level", int'(key_level), 1);
    check("held_run_active", int'(run_active), 0);
    key_n = 1'b1;
    ticks(20);
    check("held_release_steps", steps, 2);
    key_n = 1'b0;
    ticks(20);
    key_n = 1'b1;
    ticks(20);
    check("repress_steps", steps, 3);
    check("repress_count", int'(step_count), 9);

    // 6. preload to 254 with run steps, then wrap
    steps   = 0;
    cyc0    = cyc;
    guard   = 0;
    run_sel = 1'b1;
    while (steps < 245 && guard < 2000) begin
      tick();
      guard++;
    end
    check("preload_steps", steps, 245);
    tick();
    check("count_254", int'(step_count), 254);
    wait_step("wrap_step_a");
    tick();
    check("count_255", int'(step_count), 255);
    wait_step("wrap_step_b");
    tick();
    check("count_0", int'(step_count), 0);
    wait_step("wrap_step_c");
    tick();
    check("count_1", int'(step_count), 1);

    // reset mid-prescale, then first auto step again RUN_DIV after re-entry
    ticks(2);
    reset = 1'b1;
    tick();
    check("midrst_step", int'(step), 0);
    check("midrst_run_active", int'(run_active), 0);
    check("midrst_count", int'(step_count), 0);
    check("midrst_key_level", int'(key_level), 0);
    tick();
    check("midrst_step_after", int'(step), 0);
    reset = 1'b0;
    steps = 0;
    step_cycles.delete();
    cyc0 = cyc;
    ticks(12);
    check("post_rst_steps", steps, 1);
    check("post_rst_step_pos", (step_cycles.size() > 0) ? step_cycles[0] : -1, 8);
    run_sel = 1'b0;
    ticks(10);
    check("no_double_step", dbl, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
